instr_encoder: RTL and testbench

Sequential instruction encoder for the single-cycle MIPS core: accepts one instruction description per valid/ready handshake, packs it into a 32-bit MIPS machine word, and writes it into instruction memory at an auto-incrementing word address. It produces exactly the opcodes the control-unit main decoder consumes (R-type, lw, sw, beq, addi, j), so it loads programs in bring-up and test. It sits between a host/testbench loader and the instruction-memory write port.

---
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs one MIPS instruction description per handshake into a 32-bit word and
// writes it to instruction memory at an auto-incrementing word address.
//
// state | meaning
// IDLE  | waiting for a handshake (in_ready when not full and not clearing)
// ENC   | fields latched; encode into imem_wdata or flag an illegal class
// WRITE | imem_we high; word_count advances at the closing edge
module instr_encoder #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op_class,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [5:0]            funct,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  full,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, ENC, WRITE} state_t;

    localparam logic [ADDR_WIDTH:0] WC_ONE = 1;

    state_t                state_q;
    logic [2:0]            op_q;
    logic [4:0]            rs_q, rt_q, rd_q;
    logic [5:0]            funct_q;
    logic [15:0]           imm_q;
    logic [25:0]           target_q;
    logic [31:0]           wdata_q;
    logic [ADDR_WIDTH:0]   wc_q;
    logic                  err_q;
    logic [31:0]           enc_word_d;
    logic                  enc_legal_d;

    always_comb begin
        enc_word_d  = 32'h0;
        enc_legal_d = 1'b1;
        case (op_q)
            3'b000:  enc_word_d = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, funct_q};
            3'b001:  enc_word_d = {6'b100011, rs_q, rt_q, imm_q};
            3'b010:  enc_word_d = {6'b101011, rs_q, rt_q, imm_q};
            3'b011:  enc_word_d = {6'b000100, rs_q, rt_q, imm_q};
            3'b100:  enc_word_d = {6'b001000, rs_q, rt_q, imm_q};
            3'b101:  enc_word_d = {6'b000010, target_q};
            default: enc_legal_d = 1'b0;
        endcase
    end

    // full is the carry bit: the counter saturates at 2^ADDR_WIDTH, never wraps
    assign full       = wc_q[ADDR_WIDTH];
    assign in_ready   = (state_q == IDLE) && !full && !clear;
    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = wc_q[ADDR_WIDTH-1:0];
    assign imem_wdata = wdata_q;
    assign word_count = wc_q;
    assign err        = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            funct_q  <= 6'd0;
            imm_q    <= 16'd0;
            target_q <= 26'd0;
            wdata_q  <= 32'h0;
            wc_q     <= '0;
            err_q    <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            wc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= op_class;
                        rs_q     <= rs;
                        rt_q     <= rt;
                        rd_q     <= rd;
                        funct_q  <= funct;
                        imm_q    <= imm;
                        target_q <= target;
                        state_q  <= ENC;
                    end
                end
                ENC: begin
                    if (enc_legal_d) begin
                        wdata_q <= enc_word_d;
                        state_q <= WRITE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    wc_q    <= wc_q + WC_ONE;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (ADDR_WIDTH=2) with hand-computed machine words.
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready;
    logic [2:0]    op_class;
    logic [4:0]    rs, rt, rd;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          full, err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_wc   = 0;
    logic saw_we;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
        .target(target), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [5:0] f, input logic [15:0] i,
                         input logic [25:0] t);
        op_class = op; rs = a; rt = b; rd = c; funct = f; imm = i; target = t;
    endtask

    task automatic scramble();
        op_class = 3'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic send_legal(input string tag, input logic [2:0] op, input logic [4:0] a,
                              input logic [4:0] b, input logic [4:0] c, input logic [5:0] f,
                              input logic [15:0] i, input logic [25:0] t, input logic [31:0] word);
        wait_ready(tag);
        drive(op, a, b, c, f, i, t);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        check_val({tag, "_enc_we"}, 32'(imem_we), 32'd0);
        check_val({tag, "_enc_rdy"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check_val({tag, "_we"}, 32'(imem_we), 32'd1);
        check_val({tag, "_addr"}, 32'(imem_addr), 32'(exp_wc % 4));
        check_val({tag, "_wdata"}, imem_wdata, word);
        check_val({tag, "_wr_rdy"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        exp_wc++;
        check_val({tag, "_we_off"}, 32'(imem_we), 32'd0);
        check_val({tag, "_wc"}, 32'(word_count), 32'(exp_wc));
        check_val({tag, "_rdy"}, 32'(in_ready), 32'(exp_wc < 4));
    endtask

    task automatic send_illegal(input string tag);
        wait_ready(tag);
        drive(3'b111, 5'd3, 5'd4, 5'd5, 6'h2a, 16'hbeef, 26'h1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val({tag, "_enc_we"}, 32'(imem_we), 32'd0);
        @(posedge clk); #1;
        check_val({tag, "_err"}, 32'(err), 32'd1);
        check_val({tag, "_we"}, 32'(imem_we), 32'd0);
        check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
        check_val({tag, "_wc"}, 32'(word_count), 32'(exp_wc));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_wc = 0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        #2;
        check_val("rst_rdy", 32'(in_ready), 32'd1);
        check_val("rst_we", 32'(imem_we), 32'd0);
        check_val("rst_addr", 32'(imem_addr), 32'd0);
        check_val("rst_wdata", imem_wdata, 32'd0);
        check_val("rst_wc", 32'(word_count), 32'd0);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // R-type add $t0,$s0,$s1; stray imm/target must not leak into the word
        send_legal("rtype", 3'b000, 5'd16, 5'd17, 5'd8, 6'h20, 16'hffff, 26'h3ffffff, 32'h02114020);

        do_clear();
        check_val("clr1_wc", 32'(word_count), 32'd0);
        send_legal("lw",  3'b001, 5'd29, 5'd8, 5'd31, 6'h3f, 16'h0004, 26'h0, 32'h8FA80004);
        send_legal("beq", 3'b011, 5'd1,  5'd2, 5'd0,  6'h00, 16'hFFFF, 26'h0, 32'h1022FFFF);
        send_legal("j",   3'b101, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hFFFF, 26'h10, 32'h08000010);

        do_clear();
        send_illegal("ill");
        send_legal("addi", 3'b100, 5'd0, 5'd9, 5'd0, 6'h0, 16'h0005, 26'h0, 32'h20090005);
        check_val("ill_err_sticky", 32'(err), 32'd1);

        do_clear();
        check_val("clr_err", 32'(err), 32'd0);
        send_legal("f_sw",   3'b010, 5'd29, 5'd31, 5'd0, 6'h0,  16'h0008, 26'h0, 32'hAFBF0008);
        send_legal("f_addi", 3'b100, 5'd1,  5'd2,  5'd0, 6'h0,  16'h1234, 26'h0, 32'h20221234);
        send_legal("f_rtyp", 3'b000, 5'd1,  5'd2,  5'd3, 6'h22, 16'h0,    26'h0, 32'h00221822);
        send_legal("f_lw",   3'b001, 5'd0,  5'd4,  5'd0, 6'h0,  16'hFFFC, 26'h0, 32'h8C04FFFC);
        check_val("full_flag", 32'(full), 32'd1);
        check_val("full_wc", 32'(word_count), 32'd4);
        check_val("full_rdy", 32'(in_ready), 32'd0);
        drive(3'b100, 5'd1, 5'd1, 5'd0, 6'h0, 16'h1, 26'h0);
        in_valid = 1'b1;
        saw_we = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            saw_we |= imem_we;
        end
        in_valid = 1'b0;
        check_val("full_no_write", 32'(saw_we), 32'd0);
        check_val("full_wc_hold", 32'(word_count), 32'd4);

        // clear while an instruction sits in ENC and another handshake is offered
        do_clear();
        check_val("clr_full", 32'(full), 32'd0);
        send_illegal("pre_clr");
        send_legal("pre_clr_r", 3'b000, 5'd16, 5'd17, 5'd8, 6'h20, 16'h0, 26'h0, 32'h02114020);
        drive(3'b001, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b1;
        check_val("clr_blocks_rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        exp_wc = 0;
        check_val("clr_enc_wc", 32'(word_count), 32'd0);
        check_val("clr_enc_err", 32'(err), 32'd0);
        check_val("clr_enc_full", 32'(full), 32'd0);
        saw_we = imem_we;
        repeat (3) begin
            @(posedge clk); #1;
            saw_we |= imem_we;
        end
        check_val("clr_enc_no_write", 32'(saw_we), 32'd0);
        send_legal("post_clr_j", 3'b101, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FFFFFF, 32'h0BFFFFFF);

        // asynchronous reset in the middle of a WRITE cycle
        send_illegal("pre_rst");
        drive(3'b000, 5'd1, 5'd2, 5'd3, 6'h22, 16'h0, 26'h0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("arst_in_write", 32'(imem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_we", 32'(imem_we), 32'd0);
        check_val("arst_wc", 32'(word_count), 32'd0);
        check_val("arst_rdy", 32'(in_ready), 32'd1);
        check_val("arst_err", 32'(err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        exp_wc = 0;
        @(posedge clk); #1;
        send_legal("post_rst", 3'b100, 5'd0, 5'd9, 5'd0, 6'h0, 16'h0005, 26'h0, 32'h20090005);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
